fifo_sync: RTL and testbench
============================

// Module: fifo_sync
// PURPOSE
//  Single-clock synchronous FIFO. Buffers WIDTH-bit words between a producer and a consumer in one clock domain.
//  - Write and read handshakes are independent enables.
//  - empty/full flags are derived from registered pointers.
//  - Used as the general-purpose elastic buffer wherever rate smoothing is needed inside a clock domain.
// PARAMETERS
//  DEPTH  8   number of storage words; power of two, >= 2
//  WIDTH  32  data word width in bits
// PORTS
//  clk      in   1      clock; all logic on rising edge
//  rstN     in   1      reset; synchronous, active-high (name kept per codebase; asserted = 1)
//  wrEn     in   1      write request; sampled on rising clk
//  rdEn     in   1      read request; sampled on rising clk
//  dataIn   in   WIDTH  write data, captured when a write is accepted
//  dataOut  out  WIDTH  read data register
//  empty    out  1      1 = no stored words
//  full     out  1      1 = DEPTH words stored
// BEHAVIOUR
//  - Reset (rstN=1 at posedge):
//    - wr/rd pointers = 0, dataOut = 0, empty = 1, full = 0.
//    - Storage array is not cleared.
//    - Reset overrides any wrEn/rdEn in the same cycle.
//    - Mid-operation reset discards all contents.
//  - Pointers are log2(DEPTH)+1 bits: the low bits index memory, the MSB is the wrap bit.
//    - empty = (wr_ptr == rd_ptr).
//    - full = (low bits equal) && (MSBs differ).
//    - Both flags are combinational from registered pointers.
//  - Write accepted iff wrEn && !full:
//    - mem[wr_ptr] <= dataIn; wr_ptr++.
//    - Write while full is ignored: no pointer change, no data corruption.
//  - Read accepted iff rdEn && !empty:
//    - dataOut <= mem[rd_ptr]; rd_ptr++.
//    - Latency: data is visible on dataOut one clock after the sampling edge.
//  - Read while empty is ignored: dataOut holds its last value and rd_ptr does not move.
//  - dataOut holds its value on every cycle without an accepted read.
//  - Simultaneous wrEn && rdEn:
//    - Neither empty nor full: both performed, occupancy unchanged.
//    - Empty: only the write is performed (no fall-through).
//    - Full: only the read is performed.
//  - Pointers wrap modulo 2*DEPTH; memory address wraps modulo DEPTH. No restriction on wrap-around.
//  - Flag updates follow the pointer update edge:
//    - empty deasserts the cycle after the first accepted write.
//    - full asserts the cycle after the DEPTH-th unread write.
// CONFIGURATION
//  FIFO_STATUS_EN defined:
//    - count   out  log2(DEPTH)+1  occupancy = wr_ptr - rd_ptr.
//    - overflow   out 1  sticky, set on wrEn && full.
//    - underflow  out 1  sticky, set on rdEn && empty.
//    - All three are cleared by reset.
//  FIFO_STATUS_EN undefined:
//    - Extra ports and logic are absent.
//    - Core behaviour is identical.
// TESTING
//  1. Reset: hold rstN=1 for 2 clks -> empty=1, full=0, dataOut=0.
//  2. Over-read: write 200,201,202 (one-cycle wrEn pulses), then 6 one-cycle rdEn pulses.
//     - dataOut = 200, 201, 202 in turn.
//     - empty=1 after the 3rd read.
//     - Reads 4-6: dataOut stays 202.
//     - underflow=1 if FIFO_STATUS_EN.
//  3. Fill: write 8 words 0..7.
//     - full=1 after the 8th.
//     - 9th write (0xDEAD) is dropped.
//     - Reading 8 words returns 0..7; then empty=1.
//  4. Wrap: repeatedly write 3 / read 3 for 20 words (100..119).
//     - Read stream = 100..119 in order.
//     - Flags never falsely assert.
//  5. Simultaneous: with 4 words stored, assert wrEn+rdEn for 5 clks.
//     - Occupancy stays 4; oldest data returned in order.
//     - With FIFO_STATUS_EN, count=4 throughout.
//  6. Mid-op reset: write 5 words, assert rstN=1 for 1 clk.
//     - empty=1, dataOut=0.
//     - Next write/read of 0x55 returns 0x55.

Source files
------------

// File: rtl/fifo_sync.sv
// Single-clock synchronous FIFO with registered read data and pointer-derived flags.
// Optional status outputs (count, sticky overflow/underflow) are built when FIFO_STATUS_EN is defined.
module fifo_sync #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             wrEn,
  input  logic             rdEn,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             empty,
  output logic             full
`ifdef FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0] count,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: a write is taken on a rising edge where wrEn && !full, a read where
  // rdEn && !empty; requests that are not taken are dropped, never stalled or queued.
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wrAccept;
  logic             rdAccept;

  always_comb begin
    empty    = (wrPtr == rdPtr);
    full     = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
    wrAccept = wrEn && !full;
    rdAccept = rdEn && !empty;
  end

  always_ff @(posedge clk) begin
    if (rstN) begin
      wrPtr <= '0;
    end else if (wrAccept) begin
      wrPtr <= wrPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstN) begin
      rdPtr   <= '0;
      dataOut <= '0;
    end else if (rdAccept) begin
      rdPtr   <= rdPtr + 1'b1;
      dataOut <= mem[rdPtr[AW-1:0]];
    end
  end

  // Storage is never cleared; reset only blocks a write from landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstN && wrAccept) begin
      mem[wrPtr[AW-1:0]] <= dataIn;
    end
  end

`ifdef FIFO_STATUS_EN
  always_comb begin
    count = wrPtr - rdPtr;
  end

  always_ff @(posedge clk) begin
    if (rstN) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wrEn && full) overflow <= 1'b1;
      if (rdEn && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: reset, over-read, fill/overfill, wrap, simultaneous access, mid-op reset.
// Build with FIFO_STATUS_EN defined to also check count/overflow/underflow.
module tb_fifo_sync;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic             clk;
  logic             rstN;
  logic             wrEn;
  logic             rdEn;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic             empty;
  logic             full;
`ifdef FIFO_STATUS_EN
  logic [3:0]       count;
  logic             overflow;
  logic             underflow;
`endif

  fifo_sync #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .rstN(rstN),
    .wrEn(wrEn),
    .rdEn(rdEn),
    .dataIn(dataIn),
    .dataOut(dataOut),
    .empty(empty),
    .full(full)
`ifdef FIFO_STATUS_EN
    ,
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_dout;
  logic             exp_ovf;
  logic             exp_unf;
  int               check_cnt;
  int               fail_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".dout"}, 64'(dataOut), 64'(exp_dout));
    check({tag, ".empty"}, 64'(empty), 64'(exp_q.size() == 0));
    check({tag, ".full"}, 64'(full), 64'(exp_q.size() == DEPTH));
`ifdef FIFO_STATUS_EN
    check({tag, ".count"}, 64'(count), 64'(exp_q.size()));
    check({tag, ".ovf"}, 64'(overflow), 64'(exp_ovf));
    check({tag, ".unf"}, 64'(underflow), 64'(exp_unf));
`endif
  endtask

  // driver: one clock with the given requests; the model decides acceptance from pre-edge occupancy
  task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d, input string tag);
    int occ;
    @(negedge clk);
    wrEn = w; rdEn = r; dataIn = d;
    occ = exp_q.size();
    if (w && occ == DEPTH) exp_ovf = 1'b1;
    if (r && occ == 0) exp_unf = 1'b1;
    if (r && occ > 0) exp_dout = exp_q.pop_front();
    if (w && occ < DEPTH) exp_q.push_back(d);
    @(negedge clk);
    wrEn = 1'b0; rdEn = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rstN = 1'b1;
    repeat (n) @(negedge clk);
    rstN = 1'b0;
    exp_q.delete();
    exp_dout = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  initial begin
    check_cnt = 0; fail_cnt = 0;
    rstN = 1'b1; wrEn = 1'b0; rdEn = 1'b0; dataIn = '0;

    // 1. reset
    do_reset(2);
    check("rst.empty", 64'(empty), 64'd1);
    check("rst.full", 64'(full), 64'd0);
    check("rst.dout", 64'(dataOut), 64'd0);
    check_state("rst");

    // 2. over-read
    cycle(1, 0, 200, "or.w0");
    check("or.empty_after_w", 64'(empty), 64'd0);
    cycle(1, 0, 201, "or.w1");
    cycle(1, 0, 202, "or.w2");
    cycle(0, 1, 0, "or.r0");
    check("or.r0_val", 64'(dataOut), 64'd200);
    cycle(0, 1, 0, "or.r1");
    check("or.r1_val", 64'(dataOut), 64'd201);
    cycle(0, 1, 0, "or.r2");
    check("or.r2_val", 64'(dataOut), 64'd202);
    check("or.empty_after_r2", 64'(empty), 64'd1);
    for (int i = 3; i < 6; i++) begin
      cycle(0, 1, 0, "or.rx");
      check("or.hold", 64'(dataOut), 64'd202);
    end
`ifdef FIFO_STATUS_EN
    check("or.underflow", 64'(underflow), 64'd1);
`endif

    // 3. fill, overfill, simultaneous while full, drain
    for (int i = 0; i < DEPTH; i++) begin
      check("fill.full_before", 64'(full), 64'd0);
      cycle(1, 0, WIDTH'(i), "fill.w");
    end
    check("fill.full", 64'(full), 64'd1);
    cycle(1, 0, 32'hDEAD, "fill.drop");
    check("fill.full_kept", 64'(full), 64'd1);
`ifdef FIFO_STATUS_EN
    check("fill.overflow", 64'(overflow), 64'd1);
`endif
    cycle(1, 1, 32'hBEEF, "fill.wr_rd_full");
    check("fill.rd_only_val", 64'(dataOut), 64'd0);
    check("fill.rd_only_full", 64'(full), 64'd0);
    for (int i = 1; i < DEPTH; i++) begin
      cycle(0, 1, 0, "fill.r");
      check("fill.r_val", 64'(dataOut), 64'(i));
    end
    check("fill.empty", 64'(empty), 64'd1);

    // 4. wrap: groups of up to 3 writes then the same number of reads
    for (int base = 100; base < 120; base += 3) begin
      int n;
      n = (120 - base < 3) ? 120 - base : 3;
      for (int k = 0; k < n; k++) cycle(1, 0, WIDTH'(base + k), "wrap.w");
      for (int k = 0; k < n; k++) begin
        cycle(0, 1, 0, "wrap.r");
        check("wrap.r_val", 64'(dataOut), 64'(base + k));
      end
    end

    // 5. simultaneous with 4 stored; also no fall-through when empty
    cycle(1, 1, 32'h77, "sim.empty_wr_rd");
    check("sim.no_fallthru", 64'(dataOut), 64'd119);
    cycle(0, 1, 0, "sim.r77");
    check("sim.r77_val", 64'(dataOut), 64'h77);
    for (int i = 0; i < 4; i++) cycle(1, 0, WIDTH'(300 + i), "sim.pre");
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, WIDTH'(304 + i), "sim.both");
      check("sim.val", 64'(dataOut), 64'(300 + i));
`ifdef FIFO_STATUS_EN
      check("sim.count", 64'(count), 64'd4);
`endif
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, "sim.drain");
      check("sim.drain_val", 64'(dataOut), 64'(305 + i));
    end

    // 6. mid-op reset
    for (int i = 0; i < 5; i++) cycle(1, 0, WIDTH'(400 + i), "mid.w");
    cycle(0, 1, 0, "mid.r");
    do_reset(1);
    check("mid.empty", 64'(empty), 64'd1);
    check("mid.dout", 64'(dataOut), 64'd0);
    check("mid.full", 64'(full), 64'd0);
    check_state("mid.rst");
    cycle(1, 0, 32'h55, "mid.w55");
    cycle(0, 1, 0, "mid.r55");
    check("mid.r55_val", 64'(dataOut), 64'h55);
    check("mid.empty_end", 64'(empty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
